// File: rtl/cpu_mon_pkg.sv
// Shared types for the run monitor: verdict state encoding and PC-match helpers.
// Pure declarations, no logic or timing.
package cpu_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RUN        = 3'd1,
        ST_PASS       = 3'd2,
        ST_FAIL_TO    = 3'd3,
        ST_FAIL_NOVLD = 3'd4,
        ST_FAIL_STALL = 3'd5,
        ST_FAIL_PC    = 3'd6
    } mon_state_e;

    // All-ones PC means "match disabled"; sliced down to the PC width at use.
    localparam logic [63:0] MON_PC_DISABLED = '1;

    function automatic logic is_terminal(input mon_state_e s);
        return (s != ST_IDLE) && (s != ST_RUN);
    endfunction

endpackage

// File: rtl/cpu_run_monitor_if.sv
// Core tap inputs and monitor result outputs bundled for the run monitor.
// Pure wiring, no latency; no backpressure (the core is never stalled).
interface cpu_run_monitor_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic             i_en;
    logic [PC_W-1:0]  i_pc;
    logic             i_insn_vld;
    logic [CNT_W-1:0] o_cycles;
    logic [CNT_W-1:0] o_retired;
    logic             o_sample_stb;
    logic [PC_W-1:0]  o_sample_pc;
    logic             o_sample_vld;
    logic [2:0]       o_state;
    logic             o_done;
    logic             o_pass;

    modport master (
        output i_en, i_pc, i_insn_vld,
        input  o_cycles, o_retired, o_sample_stb, o_sample_pc, o_sample_vld,
               o_state, o_done, o_pass
    );

    modport slave (
        input  i_en, i_pc, i_insn_vld,
        output o_cycles, o_retired, o_sample_stb, o_sample_pc, o_sample_vld,
               o_state, o_done, o_pass
    );
endinterface

// File: rtl/mon_sat_counter.sv
// Saturating up-counter with synchronous clear; value visible one cycle after inc.
// No backpressure: inc is a hold/advance enable, the count sticks at all-ones.
module mon_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run supervisor for the single-cycle core: counts cycles/retires, samples PC, latches a sticky verdict.
// Verdicts and samples are registered (visible one cycle later); i_en=0 pauses everything, the core is never stalled.
module cpu_run_monitor
    import cpu_mon_pkg::*;
#(
    parameter int              PC_W          = 32,
    parameter int              CNT_W         = 32,
    parameter int              TIMEOUT       = 2000,
    parameter int              SAMPLE_PERIOD = 100,
    parameter int              STALL_LIMIT   = 64,
    parameter logic [PC_W-1:0] PASS_PC       = '1,
    parameter logic [PC_W-1:0] FAIL_PC       = '1
) (
    input logic               i_clk,
    input logic               i_rst_n,
    cpu_run_monitor_if.slave  mon
);

    localparam int   STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
    localparam int   SMP_W   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic PASS_EN = (PASS_PC != MON_PC_DISABLED[PC_W-1:0]);
    localparam logic FAIL_EN = (FAIL_PC != MON_PC_DISABLED[PC_W-1:0]);

    mon_state_e         state;
    mon_state_e         verdict;
    logic               seen_vld;
    logic [STALL_W-1:0] stall_cnt;
    logic [SMP_W-1:0]   sample_cnt;
    logic [CNT_W-1:0]   cycles;
    logic [CNT_W-1:0]   retired;
    logic               sample_stb;
    logic [PC_W-1:0]    sample_pc;
    logic               sample_vld;

    logic active, vld;
    logic hit_fail, hit_pass, hit_stall, hit_to;

    assign vld       = mon.i_insn_vld;
    assign active    = (state == ST_RUN) && mon.i_en;
    assign hit_fail  = vld && FAIL_EN && (mon.i_pc == FAIL_PC);
    assign hit_pass  = vld && PASS_EN && (mon.i_pc == PASS_PC);
    assign hit_stall = !vld && seen_vld && (stall_cnt == STALL_W'(STALL_LIMIT - 1));
    assign hit_to    = (cycles == CNT_W'(TIMEOUT - 1));

    // Priority order: fail PC, pass PC, stall, then the timeout resolution.
    always_comb begin
        verdict = ST_RUN;
        if (hit_fail) begin
            verdict = ST_FAIL_PC;
        end else if (hit_pass) begin
            verdict = ST_PASS;
        end else if (hit_stall) begin
            verdict = ST_FAIL_STALL;
        end else if (hit_to) begin
            if (!(seen_vld || vld)) begin
                verdict = ST_FAIL_NOVLD;
            end else if (!PASS_EN) begin
                verdict = ST_PASS;
            end else begin
                verdict = ST_FAIL_TO;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            seen_vld   <= 1'b0;
            stall_cnt  <= '0;
            sample_cnt <= '0;
            sample_stb <= 1'b0;
            sample_pc  <= '0;
            sample_vld <= 1'b0;
        end else begin
            sample_stb <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mon.i_en) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (mon.i_en) begin
                        state     <= verdict;
                        seen_vld  <= seen_vld | vld;
                        stall_cnt <= vld ? '0 : (seen_vld ? stall_cnt + STALL_W'(1) : '0);
                        // The verdict cycle still counts but does not raise a sample pulse.
                        if (verdict == ST_RUN) begin
                            if (sample_cnt == '0) begin
                                sample_stb <= 1'b1;
                                sample_pc  <= mon.i_pc;
                                sample_vld <= vld;
                                sample_cnt <= SMP_W'(SAMPLE_PERIOD - 1);
                            end else begin
                                sample_cnt <= sample_cnt - SMP_W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    mon_sat_counter #(.W(CNT_W)) u_cycles (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (state == ST_IDLE),
        .inc   (active),
        .q     (cycles)
    );

    mon_sat_counter #(.W(CNT_W)) u_retired (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (state == ST_IDLE),
        .inc   (active && vld),
        .q     (retired)
    );

    assign mon.o_cycles     = cycles;
    assign mon.o_retired    = retired;
    assign mon.o_sample_stb = sample_stb;
    assign mon.o_sample_pc  = sample_pc;
    assign mon.o_sample_vld = sample_vld;
    assign mon.o_state      = state;
    assign mon.o_done       = is_terminal(state);
    assign mon.o_pass       = (state == ST_PASS);

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: four parameterisations driven side by side,
// directed scenarios plus random stimulus against a per-cycle reference model.
module tb_cpu_run_monitor;

    localparam int          N   = 4;
    localparam logic [31:0] DIS = 32'hFFFF_FFFF;

    typedef struct {
        int          timeout;
        int          period;
        int          stall_limit;
        logic [31:0] pass_pc;
        logic [31:0] fail_pc;
    } cfg_t;

    typedef struct {
        int          state;
        longint      cycles;
        longint      retired;
        int          idle_run;
        bit          seen;
        bit          stb;
        logic [31:0] spc;
        bit          svld;
    } mdl_t;

    logic        clk;
    logic        rst_n;
    logic        en   [N];
    logic [31:0] pc   [N];
    logic        vld  [N];
    logic [2:0]  st   [N];
    logic [31:0] cyc  [N];
    logic [31:0] ret  [N];
    logic [31:0] spc  [N];
    logic        stb  [N];
    logic        svld [N];
    logic        done [N];
    logic        pas  [N];

    cfg_t cfg [N];
    mdl_t m   [N];
    int   n_cmp = 0;
    int   n_bad = 0;

    cpu_run_monitor_if #(.PC_W(32), .CNT_W(32)) if0 ();
    cpu_run_monitor_if #(.PC_W(32), .CNT_W(32)) if1 ();
    cpu_run_monitor_if #(.PC_W(32), .CNT_W(32)) if2 ();
    cpu_run_monitor_if #(.PC_W(32), .CNT_W(32)) if3 ();

    cpu_run_monitor u0 (.i_clk(clk), .i_rst_n(rst_n), .mon(if0));
    cpu_run_monitor #(.TIMEOUT(50), .SAMPLE_PERIOD(6)) u1 (.i_clk(clk), .i_rst_n(rst_n), .mon(if1));
    cpu_run_monitor #(.STALL_LIMIT(8), .PASS_PC(32'h40)) u2 (.i_clk(clk), .i_rst_n(rst_n), .mon(if2));
    cpu_run_monitor #(.PASS_PC(32'h10), .FAIL_PC(32'h10)) u3 (.i_clk(clk), .i_rst_n(rst_n), .mon(if3));

    assign if0.i_en = en[0]; assign if0.i_pc = pc[0]; assign if0.i_insn_vld = vld[0];
    assign if1.i_en = en[1]; assign if1.i_pc = pc[1]; assign if1.i_insn_vld = vld[1];
    assign if2.i_en = en[2]; assign if2.i_pc = pc[2]; assign if2.i_insn_vld = vld[2];
    assign if3.i_en = en[3]; assign if3.i_pc = pc[3]; assign if3.i_insn_vld = vld[3];

    assign st[0] = if0.o_state; assign cyc[0] = if0.o_cycles; assign ret[0] = if0.o_retired;
    assign stb[0] = if0.o_sample_stb; assign spc[0] = if0.o_sample_pc; assign svld[0] = if0.o_sample_vld;
    assign done[0] = if0.o_done; assign pas[0] = if0.o_pass;
    assign st[1] = if1.o_state; assign cyc[1] = if1.o_cycles; assign ret[1] = if1.o_retired;
    assign stb[1] = if1.o_sample_stb; assign spc[1] = if1.o_sample_pc; assign svld[1] = if1.o_sample_vld;
    assign done[1] = if1.o_done; assign pas[1] = if1.o_pass;
    assign st[2] = if2.o_state; assign cyc[2] = if2.o_cycles; assign ret[2] = if2.o_retired;
    assign stb[2] = if2.o_sample_stb; assign spc[2] = if2.o_sample_pc; assign svld[2] = if2.o_sample_vld;
    assign done[2] = if2.o_done; assign pas[2] = if2.o_pass;
    assign st[3] = if3.o_state; assign cyc[3] = if3.o_cycles; assign ret[3] = if3.o_retired;
    assign stb[3] = if3.o_sample_stb; assign spc[3] = if3.o_sample_pc; assign svld[3] = if3.o_sample_vld;
    assign done[3] = if3.o_done; assign pas[3] = if3.o_pass;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    function automatic mdl_t mzero();
        mdl_t z;
        z.state = 0; z.cycles = 0; z.retired = 0; z.idle_run = 0;
        z.seen = 1'b0; z.stb = 1'b0; z.spc = '0; z.svld = 1'b0;
        return z;
    endfunction

    // One clock edge of the monitor's documented behaviour; sampling is by active-cycle index.
    function automatic mdl_t mstep(input cfg_t c, input mdl_t cur, input bit e, input logic [31:0] p, input bit v);
        mdl_t n = cur;
        int   verdict = 1;
        n.stb = 1'b0;
        if (cur.state == 0) begin
            if (e) n.state = 1;
            return n;
        end
        if (cur.state != 1 || !e) return n;
        if (v && c.fail_pc != DIS && p == c.fail_pc)                          verdict = 6;
        else if (v && c.pass_pc != DIS && p == c.pass_pc)                     verdict = 2;
        else if (!v && cur.seen && cur.idle_run == c.stall_limit - 1)         verdict = 5;
        else if (cur.cycles == longint'(c.timeout - 1))
            verdict = !(cur.seen || v) ? 4 : ((c.pass_pc == DIS) ? 2 : 3);
        if (verdict == 1 && (cur.cycles % c.period) == 0) begin
            n.stb  = 1'b1;
            n.spc  = p;
            n.svld = v;
        end
        n.state    = verdict;
        n.cycles   = cur.cycles + 1;
        n.retired  = cur.retired + (v ? 1 : 0);
        n.seen     = cur.seen | v;
        n.idle_run = v ? 0 : (cur.seen ? cur.idle_run + 1 : 0);
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < N; k++) m[k] = mstep(cfg[k], m[k], en[k], pc[k], vld[k]);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            en[k] = 1'b0; vld[k] = 1'b0; pc[k] = '0; m[k] = mzero();
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < N; k++) begin
            n_cmp++; if (st[k] !== 3'd0)   begin n_bad++; $display("FAIL rst_state[%0d] got %0d exp 0", k, st[k]); end
            n_cmp++; if (cyc[k] !== 32'd0) begin n_bad++; $display("FAIL rst_cycles[%0d] got %0d exp 0", k, cyc[k]); end
            n_cmp++; if (ret[k] !== 32'd0) begin n_bad++; $display("FAIL rst_retired[%0d] got %0d exp 0", k, ret[k]); end
            n_cmp++; if ({stb[k], svld[k], done[k], pas[k], spc[k]} !== 36'd0)
                begin n_bad++; $display("FAIL rst_misc[%0d] got %h exp 0", k, {stb[k], svld[k], done[k], pas[k], spc[k]}); end
        end
    endtask

    task automatic test_default_pass();
        logic [31:0] expq[$];
        logic [31:0] gotq[$];
        int i;
        do_reset();
        en[0] = 1'b1;
        tick();
        for (i = 0; i < 2010 && !done[0]; i++) begin
            vld[0] = 1'b1;
            pc[0]  = $urandom;
            if (i % 100 == 0) expq.push_back(pc[0]);
            tick();
            if (stb[0]) gotq.push_back(spc[0]);
        end
        n_cmp++; if (i !== 2000)         begin n_bad++; $display("FAIL dflt_done_cycle got %0d exp 2000", i); end
        n_cmp++; if (st[0] !== 3'd2)     begin n_bad++; $display("FAIL dflt_state got %0d exp 2", st[0]); end
        n_cmp++; if (cyc[0] !== 32'd2000) begin n_bad++; $display("FAIL dflt_cycles got %0d exp 2000", cyc[0]); end
        n_cmp++; if (ret[0] !== 32'd2000) begin n_bad++; $display("FAIL dflt_retired got %0d exp 2000", ret[0]); end
        n_cmp++; if (pas[0] !== 1'b1 || done[0] !== 1'b1)
            begin n_bad++; $display("FAIL dflt_pass_done got %b%b exp 11", pas[0], done[0]); end
        n_cmp++; if (gotq.size() !== 20) begin n_bad++; $display("FAIL dflt_nsamples got %0d exp 20", gotq.size()); end
        for (int s = 0; s < 20 && s < gotq.size(); s++) begin
            n_cmp++; if (gotq[s] !== expq[s])
                begin n_bad++; $display("FAIL dflt_sample_pc[%0d] got %h exp %h", s, gotq[s], expq[s]); end
        end
        repeat (3) begin
            tick();
            n_cmp++; if (stb[0] !== 1'b0 || cyc[0] !== 32'd2000)
                begin n_bad++; $display("FAIL dflt_frozen got stb=%b cyc=%0d exp 0/2000", stb[0], cyc[0]); end
        end
    endtask

    task automatic test_novld();
        int i;
        bit saw_stall = 1'b0;
        do_reset();
        en[1] = 1'b1;
        tick();
        for (i = 0; i < 60 && !done[1]; i++) begin
            vld[1] = 1'b0;
            pc[1]  = $urandom;
            tick();
            if (st[1] == 3'd5) saw_stall = 1'b1;
        end
        n_cmp++; if (i !== 50)           begin n_bad++; $display("FAIL novld_done_cycle got %0d exp 50", i); end
        n_cmp++; if (st[1] !== 3'd4)     begin n_bad++; $display("FAIL novld_state got %0d exp 4", st[1]); end
        n_cmp++; if (cyc[1] !== 32'd50)  begin n_bad++; $display("FAIL novld_cycles got %0d exp 50", cyc[1]); end
        n_cmp++; if (ret[1] !== 32'd0)   begin n_bad++; $display("FAIL novld_retired got %0d exp 0", ret[1]); end
        n_cmp++; if (pas[1] !== 1'b0)    begin n_bad++; $display("FAIL novld_pass got %b exp 0", pas[1]); end
        n_cmp++; if (saw_stall !== 1'b0) begin n_bad++; $display("FAIL novld_stall got 1 exp 0"); end
    endtask

    task automatic test_pass_pc();
        int i;
        logic [31:0] pcv = '0;
        do_reset();
        en[2] = 1'b1;
        tick();
        for (i = 0; i < 40 && !done[2]; i++) begin
            vld[2] = 1'b1;
            pc[2]  = pcv;
            pcv    = pcv + 32'd4;
            tick();
        end
        n_cmp++; if (i !== 17)           begin n_bad++; $display("FAIL passpc_done_cycle got %0d exp 17", i); end
        n_cmp++; if (st[2] !== 3'd2)     begin n_bad++; $display("FAIL passpc_state got %0d exp 2", st[2]); end
        n_cmp++; if (ret[2] !== 32'd17)  begin n_bad++; $display("FAIL passpc_retired got %0d exp 17", ret[2]); end
        n_cmp++; if (pas[2] !== 1'b1)    begin n_bad++; $display("FAIL passpc_pass got %b exp 1", pas[2]); end
    endtask

    task automatic test_stall();
        int idle = 0;
        do_reset();
        en[2] = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            vld[2] = 1'b1;
            pc[2]  = 32'h100 + 32'(i * 4);
            tick();
        end
        for (int i = 0; i < 30 && !done[2]; i++) begin
            vld[2] = 1'b0;
            tick();
            idle++;
        end
        n_cmp++; if (idle !== 8)         begin n_bad++; $display("FAIL stall_idle got %0d exp 8", idle); end
        n_cmp++; if (st[2] !== 3'd5)     begin n_bad++; $display("FAIL stall_state got %0d exp 5", st[2]); end
        n_cmp++; if (cyc[2] !== 32'd11)  begin n_bad++; $display("FAIL stall_cycles got %0d exp 11", cyc[2]); end
        n_cmp++; if (ret[2] !== 32'd3)   begin n_bad++; $display("FAIL stall_retired got %0d exp 3", ret[2]); end
    endtask

    task automatic test_priority();
        do_reset();
        en[3] = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            vld[3] = 1'b1;
            pc[3]  = 32'h20 + 32'(i * 4);
            tick();
        end
        n_cmp++; if (st[3] !== 3'd1)     begin n_bad++; $display("FAIL prio_running got %0d exp 1", st[3]); end
        pc[3] = 32'h10;
        tick();
        n_cmp++; if (st[3] !== 3'd6)     begin n_bad++; $display("FAIL prio_state got %0d exp 6", st[3]); end
        n_cmp++; if (pas[3] !== 1'b0 || done[3] !== 1'b1)
            begin n_bad++; $display("FAIL prio_pass_done got %b%b exp 01", pas[3], done[3]); end
        n_cmp++; if (cyc[3] !== 32'd4)   begin n_bad++; $display("FAIL prio_cycles got %0d exp 4", cyc[3]); end
    endtask

    task automatic test_pause();
        do_reset();
        en[0] = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            vld[0] = 1'b1; pc[0] = $urandom;
            tick();
        end
        n_cmp++; if (cyc[0] !== 32'd10) begin n_bad++; $display("FAIL pause_pre got %0d exp 10", cyc[0]); end
        for (int i = 0; i < 5; i++) begin
            en[0] = 1'b0; vld[0] = 1'($urandom_range(0, 1)); pc[0] = $urandom;
            tick();
            n_cmp++; if (cyc[0] !== 32'd10 || ret[0] !== 32'd10 || stb[0] !== 1'b0 || st[0] !== 3'd1)
                begin n_bad++; $display("FAIL pause_gap got cyc=%0d ret=%0d stb=%b st=%0d exp 10/10/0/1", cyc[0], ret[0], stb[0], st[0]); end
        end
        en[0] = 1'b1; vld[0] = 1'b1;
        tick();
        n_cmp++; if (cyc[0] !== 32'd11) begin n_bad++; $display("FAIL pause_resume got %0d exp 11", cyc[0]); end
    endtask

    task automatic test_async_reset();
        do_reset();
        en[0] = 1'b1;
        tick();
        for (int i = 0; i < 37; i++) begin
            vld[0] = 1'b1; pc[0] = $urandom;
            tick();
        end
        n_cmp++; if (cyc[0] !== 32'd37) begin n_bad++; $display("FAIL arst_pre got %0d exp 37", cyc[0]); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (st[0] !== 3'd0 || cyc[0] !== 32'd0 || ret[0] !== 32'd0 || stb[0] !== 1'b0 || spc[0] !== 32'd0)
            begin n_bad++; $display("FAIL arst_now got st=%0d cyc=%0d ret=%0d stb=%b exp all 0", st[0], cyc[0], ret[0], stb[0]); end
        for (int k = 0; k < N; k++) begin
            en[k] = 1'b0; vld[k] = 1'b0; m[k] = mzero();
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 250; c++) begin
            en[0]  = ($urandom_range(0, 7) != 0);
            vld[0] = ($urandom_range(0, 5) != 0);
            pc[0]  = $urandom;
            tick();
            n_cmp++; if (st[0] !== 3'(m[0].state) || cyc[0] !== 32'(m[0].cycles) || ret[0] !== 32'(m[0].retired))
                begin n_bad++; $display("FAIL rerun_cnt[%0d] got st=%0d cyc=%0d ret=%0d exp %0d/%0d/%0d", c, st[0], cyc[0], ret[0], m[0].state, m[0].cycles, m[0].retired); end
            n_cmp++; if (stb[0] !== m[0].stb || spc[0] !== m[0].spc || svld[0] !== m[0].svld)
                begin n_bad++; $display("FAIL rerun_sample[%0d] got %b/%h/%b exp %b/%h/%b", c, stb[0], spc[0], svld[0], m[0].stb, m[0].spc, m[0].svld); end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                for (int k = 0; k < N; k++) begin
                    en[k]  = ($urandom_range(0, 9) != 0);
                    vld[k] = ($urandom_range(0, 3) != 0);
                    pc[k]  = 32'($urandom_range(0, 63) * 4);
                end
                tick();
                for (int k = 0; k < N; k++) begin
                    n_cmp++; if (st[k] !== 3'(m[k].state) || done[k] !== (m[k].state >= 2) || pas[k] !== (m[k].state == 2))
                        begin n_bad++; $display("FAIL rnd_state[%0d][%0d] got %0d exp %0d", k, c, st[k], m[k].state); end
                    n_cmp++; if (cyc[k] !== 32'(m[k].cycles) || ret[k] !== 32'(m[k].retired))
                        begin n_bad++; $display("FAIL rnd_cnt[%0d][%0d] got %0d/%0d exp %0d/%0d", k, c, cyc[k], ret[k], m[k].cycles, m[k].retired); end
                    n_cmp++; if (stb[k] !== m[k].stb || spc[k] !== m[k].spc || svld[k] !== m[k].svld)
                        begin n_bad++; $display("FAIL rnd_sample[%0d][%0d] got %b/%h/%b exp %b/%h/%b", k, c, stb[k], spc[k], svld[k], m[k].stb, m[k].spc, m[k].svld); end
                end
            end
        end
    endtask

    initial begin
        cfg[0] = '{timeout: 2000, period: 100, stall_limit: 64, pass_pc: DIS,      fail_pc: DIS};
        cfg[1] = '{timeout: 50,   period: 6,   stall_limit: 64, pass_pc: DIS,      fail_pc: DIS};
        cfg[2] = '{timeout: 2000, period: 100, stall_limit: 8,  pass_pc: 32'h40,   fail_pc: DIS};
        cfg[3] = '{timeout: 2000, period: 100, stall_limit: 64, pass_pc: 32'h10,   fail_pc: 32'h10};
        test_reset();
        test_default_pass();
        test_novld();
        test_pass_pc();
        test_stall();
        test_priority();
        test_pause();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
